spu_mald_mq: RTL and testbench

Parametrised multi-outstanding load sequencer for the SPU modular-arithmetic (MA) unit. It fetches `len` 64-bit operand words from L2 into MA memory. It issues line requests to the LSU interface, with up to `MAX_OUTST` requests in flight, and writes each returned line word-by-word into MA memory. It also handles unaligned starts, uncorrectable-error and stxa force aborts, and the sticky load-done status returned on the next masync.

---
 rtl/spu_mald_mq_if.sv | 20 ++
 rtl/spu_mald_mq.sv | 167 ++++++++++++++++
 tb/tb_spu_mald_mq.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spu_mald_mq_if.sv
// LSU-side request/line-return channel of the MA load sequencer.
// ldreq is held until ldreq_ack; a request transfers on the cycle both are high.
interface spu_mald_mq_if;
    logic ldreq;
    logic ldreq_ack;
    logic ln_received;
    logic unc_err;
    logic mpa_inc;
    logic rstln;

    modport master (
        output ldreq, mpa_inc, rstln,
        input  ldreq_ack, ln_received, unc_err
    );

    modport slave (
        input  ldreq, mpa_inc, rstln,
        output ldreq_ack, ln_received, unc_err
    );
endinterface

// File: rtl/spu_mald_mq.sv
// Multi-outstanding L2->MA memory load sequencer with line request and line write FSMs.
// Define SPU_MALD_PREFETCH_EN to allow MAX_OUTST overlapped requests; otherwise strictly serial.
module spu_mald_mq #(
    parameter int LEN_W     = 6,
    parameter int WPL       = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic                         rclk,
    input  logic                         arst_l,
    input  logic                         se,
    input  logic                         start,
    input  logic                         ldop,
    input  logic [LEN_W-1:0]             len,
    input  logic [$clog2(WPL)-1:0]       start_ofs,
    spu_mald_mq_if.master                lsu,
    input  logic                         stxa_abort,
    output logic                         memwen,
    output logic [$clog2(WPL)-1:0]       word_sel,
    output logic                         maaddr_inc,
    output logic                         busy,
    output logic                         done,
    output logic                         done_set,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt,
    output logic [3:0]                   dbg_state
);
    localparam int OFS_W = $clog2(WPL);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;
`ifdef SPU_MALD_PREFETCH_EN
    localparam int LIMIT = MAX_OUTST;
`else
    localparam int LIMIT = 1;
`endif

    typedef enum logic [1:0] {R_IDLE, R_REQ, R_HOLD} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_CAP, W_WR} w_state_t;

    r_state_t         r_rst;
    w_state_t         r_wst;
    logic [LEN_W-1:0] r_wrem;
    logic [LEN_W:0]   r_lreq;
    logic [OFS_W-1:0] r_wofs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_done_set;
    logic             r_maaddr_inc;

    logic             w_start;
    logic             w_accept;
    logic             w_wr;
    logic             w_line_end;
    logic             w_abort;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [LEN_W:0]   w_lreq_sum;
    logic [LEN_W:0]   w_lreq_init;
    logic             w_unused;

    assign w_unused    = se;
    assign w_start     = start & ldop & ~r_busy;
    assign w_accept    = (r_rst == R_REQ) & lsu.ldreq_ack;
    assign w_wr        = (r_wst == W_WR);
    assign w_line_end  = w_wr & ((r_wofs == OFS_W'(WPL - 1)) | (r_wrem == LEN_W'(1)));
    assign w_abort     = lsu.unc_err | (stxa_abort & w_wr);
    assign w_cnt_nxt   = r_cnt + CNT_W'(w_accept) - CNT_W'(w_line_end);
    // Lines touched = ceil((start_ofs + len) / WPL).
    assign w_lreq_sum  = {1'b0, len} + (LEN_W+1)'(start_ofs) + (LEN_W+1)'(WPL - 1);
    assign w_lreq_init = w_lreq_sum >> OFS_W;

    assign lsu.ldreq   = (r_rst == R_REQ);
    assign lsu.mpa_inc = w_accept;
    assign lsu.rstln   = w_line_end | w_abort;
    assign memwen      = w_wr;
    assign word_sel    = r_wofs;
    assign maaddr_inc  = r_maaddr_inc;
    assign busy        = r_busy;
    assign done        = r_done;
    assign done_set    = r_done_set;
    assign outst_cnt   = r_cnt;
    assign dbg_state   = {r_rst, r_wst};

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_rst        <= R_IDLE;
            r_wst        <= W_IDLE;
            r_wrem       <= '0;
            r_lreq       <= '0;
            r_wofs       <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_done_set   <= 1'b0;
            r_maaddr_inc <= 1'b0;
        end else begin
            r_maaddr_inc <= w_wr;
            r_done       <= 1'b0;

            if (w_start)
                r_done_set <= 1'b0;
            else if ((r_done | w_abort) & ldop)
                r_done_set <= 1'b1;

            if (w_abort) begin
                // Lines still in flight are drained by the LSU; nothing is retained here.
                r_rst  <= R_IDLE;
                r_wst  <= W_IDLE;
                r_wrem <= '0;
                r_lreq <= '0;
                r_wofs <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else if (w_start) begin
                r_wrem <= len;
                r_lreq <= w_lreq_init;
                r_wofs <= start_ofs;
                r_cnt  <= '0;
                if (len == '0) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end else begin
                    r_busy <= 1'b1;
                    r_rst  <= R_REQ;
                    r_wst  <= W_WAIT;
                end
            end else begin
                r_cnt <= w_cnt_nxt;

                case (r_rst)
                    R_REQ: begin
                        if (w_accept) begin
                            r_lreq <= r_lreq - (LEN_W+1)'(1);
                            if (r_lreq == (LEN_W+1)'(1))
                                r_rst <= R_IDLE;
                            else if (w_cnt_nxt >= CNT_W'(LIMIT))
                                r_rst <= R_HOLD;
                        end
                    end
                    R_HOLD: begin
                        if (w_line_end)
                            r_rst <= R_REQ;
                    end
                    default: ;
                endcase

                case (r_wst)
                    W_WAIT: begin
                        if (lsu.ln_received && (r_cnt != '0))
                            r_wst <= W_CAP;
                    end
                    W_CAP: r_wst <= W_WR;
                    W_WR: begin
                        r_wrem <= r_wrem - LEN_W'(1);
                        r_wofs <= w_line_end ? '0 : r_wofs + OFS_W'(1);
                        if (w_line_end && (r_wrem == LEN_W'(1))) begin
                            r_wst  <= W_IDLE;
                            r_rst  <= R_IDLE;
                            r_busy <= 1'b0;
                            r_done <= 1'b1;
                        end else if (w_line_end) begin
                            r_wst <= W_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spu_mald_mq.sv
// Randomised bench for spu_mald_mq: LSU responder, word-order scoreboard and timing monitor.
module tb_spu_mald_mq;
    localparam int LEN_W     = 6;
    localparam int WPL       = 2;
    localparam int MAX_OUTST = 2;
    localparam int OFS_W     = $clog2(WPL);
    localparam int CNT_W     = $clog2(MAX_OUTST) + 1;
`ifdef SPU_MALD_PREFETCH_EN
    localparam int LIM = MAX_OUTST;
`else
    localparam int LIM = 1;
`endif

    logic             rclk = 1'b0;
    logic             arst_l = 1'b0;
    logic             se = 1'b0;
    logic             start = 1'b0;
    logic             ldop = 1'b0;
    logic             stxa_abort = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [OFS_W-1:0] start_ofs = '0;
    logic             memwen;
    logic [OFS_W-1:0] word_sel;
    logic             maaddr_inc;
    logic             busy;
    logic             done;
    logic             done_set;
    logic [CNT_W-1:0] outst_cnt;
    logic [3:0]       dbg_state;

    spu_mald_mq_if lsu_if();

    spu_mald_mq #(.LEN_W(LEN_W), .WPL(WPL), .MAX_OUTST(MAX_OUTST)) dut (
        .rclk       (rclk),
        .arst_l     (arst_l),
        .se         (se),
        .start      (start),
        .ldop       (ldop),
        .len        (len),
        .start_ofs  (start_ofs),
        .lsu        (lsu_if),
        .stxa_abort (stxa_abort),
        .memwen     (memwen),
        .word_sel   (word_sel),
        .maaddr_inc (maaddr_inc),
        .busy       (busy),
        .done       (done),
        .done_set   (done_set),
        .outst_cnt  (outst_cnt),
        .dbg_state  (dbg_state)
    );

    always #5 rclk = ~rclk;

    int cyc = 0;
    always @(posedge rclk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [OFS_W-1:0] exp_q[$];
    int               ln_q[$];
    int               n_rstln = 0;
    int               n_req = 0;
    int               n_done = 0;
    int               max_outst = 0;
    int               last_mw_cyc = 0;
    int               mon_t;
    logic             prev_mw = 1'b0;

    bit ack_always = 0;
    bit ack_block  = 0;
    bit lsu_flush  = 0;
    int pend = 0;
    bit buf_full = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // LSU model: accepts requests, returns lines oldest-first into a single line buffer.
    initial begin
        lsu_if.ldreq_ack   = 1'b0;
        lsu_if.ln_received = 1'b0;
        lsu_if.unc_err     = 1'b0;
        forever begin
            @(negedge rclk);
            if (lsu_if.ldreq && lsu_if.ldreq_ack) pend++;
            if (lsu_if.rstln) buf_full = 0;
            if (lsu_if.ln_received) begin
                if (pend > 0) pend--;
                buf_full = 1;
            end
            if (lsu_flush) begin
                pend      = 0;
                buf_full  = 0;
                lsu_flush = 0;
            end
            @(posedge rclk);
            #1;
            lsu_if.ldreq_ack   = ack_always || (!ack_block && ($urandom_range(0, 3) != 0));
            lsu_if.ln_received = (pend > 0) && !buf_full && ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: pops expected word order on every write and checks per-cycle rules.
    always @(negedge rclk) begin
        if (arst_l) begin
            if (lsu_if.ln_received) ln_q.push_back(cyc);
            if (memwen) begin
                check("write_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("word_sel", int'(word_sel), int'(exp_q.pop_front()));
                if (!prev_mw) begin
                    check("ln_before_write", int'(ln_q.size() != 0), 1);
                    if (ln_q.size() != 0) begin
                        mon_t = ln_q.pop_front();
                        check("ln_to_memwen_lat", cyc - mon_t, 2);
                    end
                end
                last_mw_cyc = cyc;
            end
            check("maaddr_inc", int'(maaddr_inc), int'(prev_mw));
            check("mpa_inc", int'(lsu_if.mpa_inc), int'(lsu_if.ldreq & lsu_if.ldreq_ack));
            check("outst_le_limit", int'(int'(outst_cnt) <= LIM), 1);
            check("no_ldreq_at_limit", int'(!(lsu_if.ldreq && int'(outst_cnt) >= LIM)), 1);
            if (int'(outst_cnt) > max_outst) max_outst = int'(outst_cnt);
            n_rstln += int'(lsu_if.rstln);
            n_req   += int'(lsu_if.ldreq & lsu_if.ldreq_ack);
            n_done  += int'(done);
            prev_mw = memwen;
        end else begin
            prev_mw = 1'b0;
        end
    end

    // mode 0: random ack, 1: ack always, 2: ack held off for the first 5 cycles
    task automatic do_op(input int l, input int o, input int mode);
        int lines;
        int k;
        lines = (l == 0) ? 0 : (o + l + WPL - 1) / WPL;
        @(negedge rclk);
        ack_always = (mode == 1);
        ack_block  = (mode == 2);
        for (int i = 0; i < l; i++) exp_q.push_back(OFS_W'((o + i) % WPL));
        n_rstln = 0; n_req = 0; n_done = 0; max_outst = 0;
        @(posedge rclk);
        #1;
        start = 1'b1; len = LEN_W'(l); start_ofs = OFS_W'(o);
        @(posedge rclk);
        #1;
        start = 1'b0;
        @(negedge rclk);
        check("ldreq_after_start", int'(lsu_if.ldreq), int'(l != 0));
        check("busy_after_start", int'(busy), int'(l != 0));
        check("done_after_start", int'(done), int'(l == 0));
        check("done_set_cleared", int'(done_set), 0);
        if (mode == 2) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge rclk);
                check("ldreq_held_stall", int'(lsu_if.ldreq), 1);
            end
            ack_block = 0;
        end
        k = 0;
        while (!done && k < 2000) begin
            @(negedge rclk);
            k++;
        end
        check("done_seen", int'(done), 1);
        check("busy_at_done", int'(busy), 0);
        if (l != 0) check("done_lat_after_last_write", cyc - last_mw_cyc, 1);
        check("words_left", exp_q.size(), 0);
        check("rstln_count", n_rstln, lines);
        check("req_count", n_req, lines);
        if (mode == 1 && l != 0) check("max_outst", max_outst, (lines < LIM) ? lines : LIM);
        @(negedge rclk);
        check("done_set_after_done", int'(done_set), 1);
        check("done_pulses", n_done, 1);
        ack_always = 0;
    endtask

    // kind 0: unc_err mid-line, kind 1: stxa_abort ignored without memwen, then effective
    task automatic do_abort(input int kind);
        int k;
        int d0;
        int o;
        o = $urandom_range(0, WPL - 1);
        @(negedge rclk);
        for (int i = 0; i < 8; i++) exp_q.push_back(OFS_W'((o + i) % WPL));
        @(posedge rclk);
        #1;
        start = 1'b1; len = LEN_W'(8); start_ofs = OFS_W'(o);
        @(posedge rclk);
        #1;
        start = 1'b0;
        if (kind == 1) begin
            stxa_abort = 1'b1;
            @(negedge rclk);
            check("stxa_no_memwen_rstln", int'(lsu_if.rstln), 0);
            @(posedge rclk);
            #1;
            stxa_abort = 1'b0;
            @(negedge rclk);
            check("stxa_no_memwen_busy", int'(busy), 1);
            @(posedge rclk);
            #1;
        end
        k = 0;
        while (!(memwen && exp_q.size() <= 6) && k < 500) begin
            @(posedge rclk);
            #1;
            k++;
        end
        check("abort_window_reached", int'(memwen), 1);
        if (kind == 0) lsu_if.unc_err = 1'b1;
        else stxa_abort = 1'b1;
        lsu_flush = 1;
        @(negedge rclk);
        check("abort_rstln", int'(lsu_if.rstln), 1);
        @(posedge rclk);
        #1;
        lsu_if.unc_err = 1'b0;
        stxa_abort = 1'b0;
        exp_q.delete();
        ln_q.delete();
        d0 = n_done;
        @(negedge rclk);
        check("abort_busy", int'(busy), 0);
        check("abort_outst", int'(outst_cnt), 0);
        check("abort_ldreq", int'(lsu_if.ldreq), 0);
        check("abort_memwen", int'(memwen), 0);
        check("abort_done", int'(done), 0);
        check("abort_done_set", int'(done_set), 1);
        repeat (10) @(negedge rclk);
        check("no_done_after_abort", n_done, d0);
    endtask

    task automatic do_reset_midop();
        @(negedge rclk);
        for (int i = 0; i < 10; i++) exp_q.push_back(OFS_W'(i % WPL));
        @(posedge rclk);
        #1;
        start = 1'b1; len = LEN_W'(10); start_ofs = '0;
        @(posedge rclk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge rclk);
        #1;
        arst_l = 1'b0;
        lsu_flush = 1;
        @(negedge rclk);
        check("rst_busy", int'(busy), 0);
        check("rst_outst", int'(outst_cnt), 0);
        check("rst_ldreq", int'(lsu_if.ldreq), 0);
        check("rst_memwen", int'(memwen), 0);
        check("rst_done_set", int'(done_set), 0);
        @(posedge rclk);
        #1;
        arst_l = 1'b1;
        exp_q.delete();
        ln_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge rclk);
        check("reset_memwen", int'(memwen), 0);
        check("reset_word_sel", int'(word_sel), 0);
        check("reset_maaddr_inc", int'(maaddr_inc), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_done_set", int'(done_set), 0);
        check("reset_outst", int'(outst_cnt), 0);
        check("reset_ldreq", int'(lsu_if.ldreq), 0);
        check("reset_mpa_inc", int'(lsu_if.mpa_inc), 0);
        check("reset_rstln", int'(lsu_if.rstln), 0);
        ldop = 1'b1;
        @(posedge rclk);
        #1;
        arst_l = 1'b1;

        do_op(4, 0, 1);
        do_op(3, 1, 0);
        do_op(6, 0, 2);
        do_op(0, 0, 0);
        do_abort(0);
        do_op(5, 1, 0);
        do_abort(1);
        do_op(2, 0, 0);
        for (int i = 0; i < 15; i++)
            do_op($urandom_range(0, 12), $urandom_range(0, WPL - 1), $urandom_range(0, 1));
        do_reset_midop();
        do_op(7, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: bench did not complete by cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
